// File: rtl/bcd_serial_subtractor.sv
// ---------------------------------------------------------------------------
// bcd_serial_subtractor: digit-serial signed-magnitude BCD subtractor |A-B|
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bcd_serial_subtractor #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] diff,
  output logic                neg,
  output logic                invalid
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state, state_next;
  logic [4*DIGITS-1:0] a_lat, b_lat;
  logic                borrow;
  logic [IW-1:0]       idx;
  logic                in_bad;
  logic                last;
  logic [3:0]          x_dig, y_dig, res_dig;
  logic                res_borrow;
  logic [4:0]          t, t_adj;

  always_comb begin
    in_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) in_bad = 1'b1;
    end
  end

  assign last = (idx == IW'(DIGITS - 1));

  // FIX reuses the digit slice as 0 - diff_k - borrow (ten's complement -> magnitude).
  always_comb begin
    x_dig      = (state == FIX) ? 4'd0 : a_lat[4*idx +: 4];
    y_dig      = (state == FIX) ? diff[4*idx +: 4] : b_lat[4*idx +: 4];
    t          = {1'b0, x_dig} - {1'b0, y_dig} - {4'd0, borrow};
    t_adj      = t + 5'd10;
    res_borrow = t[4];
    res_dig    = t[4] ? t_adj[3:0] : t[3:0];
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = in_bad ? DONE : SUB;
      SUB:     if (last) state_next = res_borrow ? FIX : DONE;
      FIX:     if (last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == SUB) || (state == FIX);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_lat   <= '0;
      b_lat   <= '0;
      diff    <= '0;
      neg     <= 1'b0;
      invalid <= 1'b0;
      borrow  <= 1'b0;
      idx     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_lat   <= a;
            b_lat   <= b;
            diff    <= '0;
            neg     <= 1'b0;
            invalid <= in_bad;
            borrow  <= 1'b0;
            idx     <= '0;
          end
        end
        SUB: begin
          diff[4*idx +: 4] <= res_dig;
          if (last) begin
            idx    <= '0;
            borrow <= 1'b0;
            neg    <= res_borrow;
          end else begin
            idx    <= idx + 1'b1;
            borrow <= res_borrow;
          end
        end
        FIX: begin
          diff[4*idx +: 4] <= res_dig;
          borrow           <= last ? 1'b0 : res_borrow;
          idx              <= last ? '0 : idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
